// File: rtl/cic3_decim_dyn.sv
// cic3_decim_dyn: third-order CIC (sinc3) decimator.
// Turns a 1-bit delta-sigma stream into signed W-bit PCM at a runtime ratio R = 2^L.
// L is sampled from log2_dec at reset and at every frame boundary.
// The output is normalised to full-scale Q(W-1) for every ratio.
// Optional build macro CIC3_SETTLE_EN hides the filter transient outputs that follow
// a reset or a ratio change.
module cic3_decim_dyn #(
  parameter int W            = 24,
  parameter int LOG2_DEC_MAX = 8,
  parameter int IW           = 3*LOG2_DEC_MAX+2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  input  logic [3:0]              log2_dec,
  output logic signed [W-1:0]     dout,
  output logic                    dout_valid,
  output logic [LOG2_DEC_MAX-1:0] frame_cnt
);

  // Headroom for the left shift applied at small ratios.
  localparam int YW = IW + W;

  // L = 0 is not a decimator, and anything above the maximum exceeds the integrator width.
  function automatic logic [3:0] clamp_l(input logic [3:0] req);
    if (req == 4'd0) return 4'd1;
    if (int'(req) > LOG2_DEC_MAX) return 4'(LOG2_DEC_MAX);
    return req;
  endfunction

  // Saturate to the W-bit signed range. Only +R^3 can actually reach this limit.
  function automatic logic signed [W-1:0] sat_w(input logic signed [YW-1:0] y);
    logic signed [YW-1:0] hi;
    logic signed [YW-1:0] lo;
    hi = {{(YW-W+1){1'b0}}, {(W-1){1'b1}}};
    lo = {{(YW-W+1){1'b1}}, {(W-1){1'b0}}};
    if (y > hi) return {1'b0, {(W-1){1'b1}}};
    if (y < lo) return {1'b1, {(W-1){1'b0}}};
    return y[W-1:0];
  endfunction

  // The CIC gain is R^3 = 2^(3L). Shift it onto Q(W-1), then saturate.
  function automatic logic signed [W-1:0] scale_c3(input logic signed [IW-1:0] c,
                                                   input logic [3:0]           l);
    logic signed [YW-1:0] y;
    int                   sh;
    y  = {{W{c[IW-1]}}, c};
    sh = 3 * int'(l) - (W - 1);
    if (sh >= 0) y = y >>> sh;
    else         y = y <<< (-sh);
    return sat_w(y);
  endfunction

  logic signed [IW-1:0]    i1_q, i2_q, i3_q;
  logic signed [IW-1:0]    d1_q, d2_q, d3_q;
  logic signed [IW-1:0]    x, c1, c2, c3;
  logic [LOG2_DEC_MAX-1:0] cnt_q, cnt_d, last_cnt;
  logic [3:0]              l_q, l_d;
  logic signed [W-1:0]     dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    strobe;
  logic                    settled;

  // Map bit 1 to +1 and bit 0 to -1.
  assign x = bit_in ? {{(IW-1){1'b0}}, 1'b1} : {IW{1'b1}};

  // The frame ends on the R-th valid bit.
  assign last_cnt = LOG2_DEC_MAX'((32'd1 << l_q) - 32'd1);
  assign strobe   = bit_valid && (cnt_q == last_cnt);

  // The comb section works on the pre-update i3.
  // All differences are modular, so integrator wrap-around cancels out.
  assign c1 = i3_q - d1_q;
  assign c2 = c1 - d2_q;
  assign c3 = c2 - d3_q;

`ifdef CIC3_SETTLE_EN
  logic [1:0] settle_q, settle_d;

  assign settled = (settle_q == 2'd3);

  // Count strobes since reset or since the last strobe that changed L.
  always_comb begin
    settle_d = settle_q;
    if (strobe) begin
      if (l_d != l_q)    settle_d = 2'd0;
      else if (!settled) settle_d = settle_q + 2'd1;
    end
  end

  // Settle counter register.
  always_ff @(posedge clk) begin
    if (rst) settle_q <= 2'd0;
    else     settle_q <= settle_d;
  end
`else
  assign settled = 1'b1;
`endif

  // Next state for the frame counter, the shadow ratio and the output register.
  always_comb begin
    cnt_d        = cnt_q;
    l_d          = l_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (strobe) begin
      cnt_d        = '0;
      l_d          = clamp_l(log2_dec);
      dout_d       = scale_c3(c3, l_q);
      dout_valid_d = settled;
    end else if (bit_valid) begin
      cnt_d = cnt_q + LOG2_DEC_MAX'(1);
    end
  end

  // Control and output registers. Reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      l_q          <= clamp_l(log2_dec);
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      l_q          <= l_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Integrator cascade. It advances only on valid bits, and every stage reads the old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q <= '0;
      i2_q <= '0;
      i3_q <= '0;
    end else if (bit_valid) begin
      i1_q <= i1_q + x;
      i2_q <= i2_q + i1_q;
      i3_q <= i3_q + i2_q;
    end
  end

  // Comb delay line. It is clocked once per frame, at the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
    end else if (strobe) begin
      d1_q <= i3_q;
      d2_q <= c1;
      d3_q <= c2;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_cic3_decim_dyn.sv
// tb_cic3_decim_dyn: randomized self-checking bench for cic3_decim_dyn.
// The reference expresses each comb input in closed form, as a binomially weighted sum of all
// bits since reset. Each output is the third difference of those per-frame sums.
module tb_cic3_decim_dyn;

  localparam int W = 24;

  logic              clk;
  logic              rst;
  logic              bit_in;
  logic              bit_valid;
  logic [3:0]        log2_dec;
  logic signed [W-1:0] dout;
  logic              dout_valid;
  logic [7:0]        frame_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state
  longint hist[$];     // +1/-1 history of accepted bits since reset
  longint s_hist[$];   // closed-form comb input at each strobe since reset
  int     m_cnt;
  int     m_l;
  longint m_dout;
  longint m_vld;
`ifdef CIC3_SETTLE_EN
  int     m_settle_left;
`endif

  cic3_decim_dyn dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .log2_dec   (log2_dec),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int clamp_ref(input int l);
    if (l == 0) return 1;
    if (l > 8)  return 8;
    return l;
  endfunction

  // Normalise the comb output, whose gain is R^3, to the Q(W-1) full-scale range.
  function automatic longint scale_ref(input longint c, input int l);
    longint y;
    int     sh;
    sh = 3 * l - (W - 1);
    if (sh >= 0) y = c >>> sh;
    else         y = c * (longint'(1) << (-sh));
    if (y > 8388607)  y = 8388607;
    if (y < -8388608) y = -8388608;
    return y;
  endfunction

  // Advance the reference by one rising edge with the given inputs.
  task automatic model_edge(input logic r, input logic bv, input logic bi, input logic [3:0] l2);
    longint s;
    longint c;
    longint a;
    longint w[4];
    int     n;
    int     k;
    int     new_l;
    w = '{1, -3, 3, -1};
    if (r) begin
      hist.delete();
      s_hist.delete();
      m_cnt  = 0;
      m_l    = clamp_ref(int'(l2));
      m_dout = 0;
      m_vld  = 0;
`ifdef CIC3_SETTLE_EN
      m_settle_left = 3;
`endif
      return;
    end
    m_vld = 0;
    if (bv) begin
      if (m_cnt == (1 << m_l) - 1) begin
        // The triple running sum over the n earlier bits weights bit j by C(n-1-j, 2).
        n = hist.size();
        s = 0;
        for (int j = 0; j < n; j++) begin
          a = longint'(n - 1 - j);
          s += hist[j] * (a * (a - 1) / 2);
        end
        s_hist.push_back(s);
        k = s_hist.size();
        c = 0;
        for (int i = 0; i < 4; i++)
          if (k - 1 - i >= 0) c += w[i] * s_hist[k-1-i];
        c = c & ((longint'(1) << 26) - 1);
        if (c >= (longint'(1) << 25)) c -= (longint'(1) << 26);
        m_dout = scale_ref(c, m_l);
        new_l  = clamp_ref(int'(l2));
`ifdef CIC3_SETTLE_EN
        m_vld = (m_settle_left == 0) ? 1 : 0;
        if (m_settle_left > 0) m_settle_left--;
        if (new_l != m_l) m_settle_left = 3;
`else
        m_vld = 1;
`endif
        m_l   = new_l;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      hist.push_back(bi ? 64'sd1 : -64'sd1);
    end
  endtask

  // Drive one clock of stimulus, update the reference, then compare just after the edge.
  task automatic step(input logic r, input logic bv, input logic bi, input logic [3:0] l2);
    rst       = r;
    bit_valid = bv;
    bit_in    = bi;
    log2_dec  = l2;
    @(posedge clk);
    model_edge(r, bv, bi, l2);
    #1;
    chk("dout_valid", longint'(dout_valid), m_vld);
    chk("frame_cnt", longint'(frame_cnt), longint'(m_cnt));
    chk("dout", longint'(dout), m_dout);
  endtask

  task automatic do_reset(input logic [3:0] l2, input int ncyc);
    for (int k = 0; k < ncyc; k++) step(1'b1, 1'b1, 1'b1, l2);
  endtask

  initial begin
    int          n;
    logic [3:0]  l2;
    int          dens;
    rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; log2_dec = 4'd4;

    // Reset held for 3 clocks with valid ones present.
    do_reset(4'd4, 3);
    chk("rst_dout", longint'(dout), 0);
    chk("rst_vld", longint'(dout_valid), 0);
    chk("rst_fc", longint'(frame_cnt), 0);

    // Constant ones, R=16.
    for (int k = 0; k < 16*8; k++) step(1'b0, 1'b1, 1'b1, 4'd4);
    chk("ones16_final", longint'(dout), 8388607);

    // Constant zeros, R=16.
    do_reset(4'd4, 1);
    for (int k = 0; k < 16*8; k++) step(1'b0, 1'b1, 1'b0, 4'd4);
    chk("zeros16_final", longint'(dout), -8388608);

    // Alternating 1010..., R=16.
    do_reset(4'd4, 1);
    for (int k = 0; k < 16*8; k++) step(1'b0, 1'b1, (k % 2) == 0, 4'd4);
    chk("alt16_final", longint'(dout), 0);

    // Constant ones, R=256.
    do_reset(4'd8, 1);
    for (int k = 0; k < 256*5; k++) step(1'b0, 1'b1, 1'b1, 4'd8);
    chk("ones256_final", longint'(dout), 8388607);

    // Gapped input: one valid bit every 3rd clock, R=4.
    do_reset(4'd2, 1);
    for (int k = 0; k < 12*10; k++) step(1'b0, (k % 3) == 2, 1'b1, 4'd2);
    chk("gap4_final", longint'(dout), 8388607);

    // Runtime ratio change 4 -> 3 at frame_cnt 7.
    do_reset(4'd4, 1);
    for (int k = 0; k < 16*3; k++) step(1'b0, 1'b1, 1'($urandom), 4'd4);
    n = 0;
    while (frame_cnt != 8'd7 && n < 64) begin
      step(1'b0, 1'b1, 1'($urandom), 4'd4);
      n++;
    end
    chk("reach_fc7", longint'(frame_cnt), 7);
    n = 0;
    do begin
      step(1'b0, 1'b1, 1'($urandom), 4'd3);
      n++;
    end while (frame_cnt != 8'd0 && n < 64);
    chk("old_frame_len", longint'(n), 9);
    n = 0;
    do begin
      step(1'b0, 1'b1, 1'($urandom), 4'd3);
      n++;
    end while (frame_cnt != 8'd0 && n < 64);
    chk("new_frame_len", longint'(n), 8);
    for (int k = 0; k < 8*6; k++) step(1'b0, 1'b1, 1'($urandom), 4'd3);

    // Reset asserted mid-frame at frame_cnt 9.
    do_reset(4'd4, 1);
    for (int k = 0; k < 16*2; k++) step(1'b0, 1'b1, 1'($urandom), 4'd4);
    n = 0;
    while (frame_cnt != 8'd9 && n < 64) begin
      step(1'b0, 1'b1, 1'($urandom), 4'd4);
      n++;
    end
    chk("reach_fc9", longint'(frame_cnt), 9);
    step(1'b1, 1'b1, 1'b1, 4'd4);
    chk("midrst_fc", longint'(frame_cnt), 0);
    chk("midrst_vld", longint'(dout_valid), 0);
    for (int k = 0; k < 16*4; k++) step(1'b0, 1'b1, 1'($urandom), 4'd4);

    // Random segments: any log2_dec (clamping included), random gaps, occasional ratio changes.
    for (int seg = 0; seg < 6; seg++) begin
      l2   = 4'($urandom_range(0, 15));
      dens = int'($urandom_range(1, 3));
      do_reset(l2, 1);
      for (int k = 0; k < 600; k++) begin
        if ($urandom_range(0, 149) == 0) l2 = 4'($urandom_range(0, 15));
        step(1'b0, $urandom_range(0, 3) < dens + 1, 1'($urandom), l2);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
